// File: rtl/axi_llc_pkg.sv
// Shared LLC types: geometry/AXI configuration structs, slave AX payload,
// LLC descriptor fields, burst codes, splitter FSM states and the line-size helper.
package axi_llc_pkg;

   localparam int unsigned AxiAddrW = 32;
   localparam int unsigned AxiIdW   = 4;

   typedef struct packed {
      int unsigned NumBlocks;
      int unsigned BlockSize;
      int unsigned SetAssociativity;
      int unsigned NumLines;
   } llc_cfg_t;

   typedef struct packed {
      int unsigned AddrWidthFull;
      int unsigned IdWidth;
      int unsigned DataWidthFull;
   } llc_axi_cfg_t;

   localparam llc_cfg_t LlcDefaultCfg = '{NumBlocks: 8, BlockSize: 64, SetAssociativity: 8, NumLines: 256};
   localparam llc_axi_cfg_t AxiDefaultCfg = '{AddrWidthFull: AxiAddrW, IdWidth: AxiIdW, DataWidthFull: 64};

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef struct packed {
      logic [AxiIdW-1:0]   id;
      logic [AxiAddrW-1:0] addr;
      logic [7:0]          len;
      logic [2:0]          size;
      logic [1:0]          burst;
      logic                lock;
      logic [3:0]          cache;
      logic [2:0]          prot;
   } llc_ax_chan_t;

   typedef struct packed {
      logic [AxiIdW-1:0]   a_x_id;
      logic [AxiAddrW-1:0] a_x_addr;
      logic [7:0]          a_x_len;
      logic [2:0]          a_x_size;
      logic [1:0]          a_x_burst;
      logic                a_x_lock;
      logic [3:0]          a_x_cache;
      logic [2:0]          a_x_prot;
      logic                rw;
      logic                x_last;
   } llc_desc_t;

   typedef enum logic {ST_IDLE, ST_SPLIT} split_state_e;

   function automatic int unsigned line_bytes(llc_cfg_t cfg);
      return cfg.NumBlocks * cfg.BlockSize / 8;
   endfunction

endpackage

// File: rtl/axi_llc_line_beats.sv
// Combinational (addr, size, beats_left) -> (beats in this line, next line address, last).
// LineBytes must be a power of two; next address wraps modulo 2^AddrW.
module axi_llc_line_beats
   import axi_llc_pkg::*;
#(
   parameter int unsigned LineBytes = 64,
   parameter int unsigned AddrW     = 32
) (
   input  logic [AxiAddrW-1:0] i_addr,
   input  logic [2:0]          i_size,
   input  logic [8:0]          i_beats,
   output logic [8:0]          o_n,
   output logic [AxiAddrW-1:0] o_next_addr,
   output logic                o_last
);

   localparam logic [AxiAddrW-1:0] LineMask = AxiAddrW'(LineBytes - 1);
   localparam logic [AxiAddrW-1:0] WrapMask =
      (AddrW >= AxiAddrW) ? '1 : AxiAddrW'((64'd1 << AddrW) - 64'd1);

   logic [AxiAddrW-1:0] w_aligned;
   logic [AxiAddrW-1:0] w_room;
   logic [AxiAddrW-1:0] w_in_line;

   assign w_aligned = i_addr & ~((AxiAddrW'(1) << i_size) - AxiAddrW'(1));
   assign w_room    = AxiAddrW'(LineBytes) - (w_aligned & LineMask);
   assign w_in_line = w_room >> i_size;

   // when not last, w_in_line < i_beats <= 256, so the low 9 bits hold it
   assign o_last      = (AxiAddrW'(i_beats) <= w_in_line);
   assign o_n         = o_last ? i_beats : w_in_line[8:0];
   assign o_next_addr = ((w_aligned & ~LineMask) + AxiAddrW'(LineBytes)) & WrapMask;

endmodule

// File: rtl/axi_llc_ax_splitter.sv
// Slave-side AX receiver: one LLC descriptor per cache line touched by a burst.
// Optional feature macro AXI_LLC_SPLIT_STATS_EN adds split_cnt_o (saturating split-burst count).
module axi_llc_ax_splitter
   import axi_llc_pkg::*;
#(
   parameter llc_cfg_t     Cfg       = LlcDefaultCfg,
   parameter llc_axi_cfg_t AxiCfg    = AxiDefaultCfg,
   parameter type          desc_t    = llc_desc_t,
   parameter type          ax_chan_t = llc_ax_chan_t,
   parameter logic         IsWrite   = 1'b0
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  ax_chan_t ax_chan_slv_i,
   input  logic     ax_chan_valid_i,
   output logic     ax_chan_ready_o,
   output desc_t    desc_o,
   output logic     desc_valid_o,
   input  logic     desc_ready_i
`ifdef AXI_LLC_SPLIT_STATS_EN
   ,
   output logic [31:0] split_cnt_o
`endif
);

   localparam int unsigned LineBytes = line_bytes(Cfg);
   localparam int unsigned AddrW     = AxiCfg.AddrWidthFull;
   localparam logic [3:0]  MaxSize   = 4'($clog2(Cfg.BlockSize / 8));

   split_state_e        r_state, w_state_next;
   ax_chan_t            r_ax, w_cur;
   logic [AxiAddrW-1:0] r_addr, w_cur_addr, w_next_addr;
   logic [8:0]          r_beats_left, w_cur_beats, w_n;
   desc_t               r_desc, w_desc;
   logic                r_desc_valid;
   logic                w_ax_ready, w_ax_hs, w_gen, w_last, w_seg_last;
   logic                w_size_legal, w_wrap_fits, w_whole;

   assign w_ax_ready = (r_state == ST_IDLE) && (!r_desc_valid || desc_ready_i);
   assign w_ax_hs    = ax_chan_valid_i && w_ax_ready;
   assign w_gen      = ((r_state == ST_SPLIT) || w_ax_hs) && (!r_desc_valid || desc_ready_i);

   // first descriptor comes straight from the slave port, later ones from the captured burst
   assign w_cur       = (r_state == ST_IDLE) ? ax_chan_slv_i : r_ax;
   assign w_cur_addr  = (r_state == ST_IDLE) ? ax_chan_slv_i.addr : r_addr;
   assign w_cur_beats = (r_state == ST_IDLE) ? ({1'b0, ax_chan_slv_i.len} + 9'd1) : r_beats_left;

   assign w_size_legal = ({1'b0, w_cur.size} <= MaxSize);
   assign w_wrap_fits  = ((32'(w_cur.len) + 32'd1) << w_cur.size) <= 32'(LineBytes);
   assign w_whole      = w_size_legal &&
                         ((w_cur.burst == BURST_FIXED) || ((w_cur.burst == BURST_WRAP) && w_wrap_fits));

   axi_llc_line_beats #(
      .LineBytes (LineBytes),
      .AddrW     (AddrW)
   ) u_line_beats (
      .i_addr      (w_cur_addr),
      .i_size      (w_cur.size),
      .i_beats     (w_cur_beats),
      .o_n         (w_n),
      .o_next_addr (w_next_addr),
      .o_last      (w_seg_last)
   );

   assign w_last = w_whole || w_seg_last;

   always_comb begin
      w_desc           = '0;
      w_desc.a_x_id    = w_cur.id;
      w_desc.a_x_addr  = w_cur_addr;
      w_desc.a_x_len   = w_whole ? w_cur.len : 8'(w_n - 9'd1);
      w_desc.a_x_size  = w_cur.size;
      w_desc.a_x_burst = w_cur.burst;
      w_desc.a_x_lock  = w_cur.lock;
      w_desc.a_x_cache = w_cur.cache;
      w_desc.a_x_prot  = w_cur.prot;
      w_desc.rw        = IsWrite;
      w_desc.x_last    = w_last;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (w_gen) w_state_next = w_last ? ST_IDLE : ST_SPLIT;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_desc_valid <= 1'b0;
         r_desc       <= '0;
      end else if (w_gen) begin
         r_desc_valid <= 1'b1;
         r_desc       <= w_desc;
      end else if (desc_ready_i) begin
         r_desc_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_gen) begin
         r_addr       <= w_next_addr;
         r_beats_left <= w_cur_beats - w_n;
         if (r_state == ST_IDLE) r_ax <= ax_chan_slv_i;
      end
   end

`ifdef AXI_LLC_SPLIT_STATS_EN
   logic [31:0] r_split_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i)                                           r_split_cnt <= '0;
      else if (w_ax_hs && !w_last && (r_split_cnt != '1)) r_split_cnt <= r_split_cnt + 32'd1;
   end

   assign split_cnt_o = r_split_cnt;
`endif

   // illegal bursts are still split as INCR after flagging
   a_size_legal : assert property (@(posedge clk_i) disable iff (rst_i) w_ax_hs |-> w_size_legal);
   a_wrap_fits  : assert property (@(posedge clk_i) disable iff (rst_i)
                                   (w_ax_hs && (ax_chan_slv_i.burst == BURST_WRAP)) |-> w_wrap_fits);

   assign ax_chan_ready_o = w_ax_ready;
   assign desc_o          = r_desc;
   assign desc_valid_o    = r_desc_valid;

endmodule

// File: tb/tb_axi_llc_ax_splitter.sv
// Bench for axi_llc_ax_splitter: AW and AR instances, beat-level reference model, directed vectors.
module tb_axi_llc_ax_splitter;
   import axi_llc_pkg::*;

   localparam llc_cfg_t     TbCfg     = '{NumBlocks: 8, BlockSize: 64, SetAssociativity: 8, NumLines: 256};
   localparam llc_axi_cfg_t TbAxiCfg  = '{AddrWidthFull: 32, IdWidth: 4, DataWidthFull: 64};
   localparam int unsigned  TB_LINE   = 64;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   llc_ax_chan_t ax = '0;
   logic         ax_valid = 1'b0;
   logic         desc_ready = 1'b1;
   logic         rdy [2];
   logic         dv  [2];
   llc_desc_t    dsc [2];
   llc_desc_t    exp_q [2][$];
   llc_desc_t    prev_d [2];
   logic         prev_stall [2];
   logic [3:0]   next_id = 4'h1;
   int           n_cmp = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

`ifdef AXI_LLC_SPLIT_STATS_EN
   logic [31:0] cnt_aw, cnt_ar;
`endif

   axi_llc_ax_splitter #(
      .Cfg(TbCfg), .AxiCfg(TbAxiCfg), .desc_t(llc_desc_t), .ax_chan_t(llc_ax_chan_t), .IsWrite(1'b1)
   ) u_aw (
      .clk_i(clk), .rst_i(rst), .ax_chan_slv_i(ax), .ax_chan_valid_i(ax_valid),
      .ax_chan_ready_o(rdy[0]), .desc_o(dsc[0]), .desc_valid_o(dv[0]), .desc_ready_i(desc_ready)
`ifdef AXI_LLC_SPLIT_STATS_EN
      , .split_cnt_o(cnt_aw)
`endif
   );

   axi_llc_ax_splitter #(
      .Cfg(TbCfg), .AxiCfg(TbAxiCfg), .desc_t(llc_desc_t), .ax_chan_t(llc_ax_chan_t), .IsWrite(1'b0)
   ) u_ar (
      .clk_i(clk), .rst_i(rst), .ax_chan_slv_i(ax), .ax_chan_valid_i(ax_valid),
      .ax_chan_ready_o(rdy[1]), .desc_o(dsc[1]), .desc_valid_o(dv[1]), .desc_ready_i(desc_ready)
`ifdef AXI_LLC_SPLIT_STATS_EN
      , .split_cnt_o(cnt_ar)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: walk the burst beat by beat and group consecutive beats by cache line.
   task automatic model_push(input int k, input llc_ax_chan_t a, input logic rw);
      llc_desc_t   d;
      int unsigned nb, sz, cnt;
      logic [31:0] ba, line;
      nb = 32'(a.len) + 32'd1;
      sz = 32'd1 << a.size;
      cnt = 0;
      line = '0;
      d = '0;
      d.a_x_id = a.id; d.a_x_size = a.size; d.a_x_burst = a.burst;
      d.a_x_lock = a.lock; d.a_x_cache = a.cache; d.a_x_prot = a.prot; d.rw = rw;
      if (a.burst == BURST_FIXED || (a.burst == BURST_WRAP && nb * sz <= TB_LINE)) begin
         d.a_x_addr = a.addr; d.a_x_len = a.len; d.x_last = 1'b1;
         exp_q[k].push_back(d);
      end else begin
         for (int unsigned i = 0; i < nb; i++) begin
            ba = (i == 0) ? a.addr : ((a.addr & ~(sz - 1)) + i * sz);
            if (cnt != 0 && (ba / TB_LINE) != line) begin
               d.a_x_len = 8'(cnt - 1); d.x_last = 1'b0;
               exp_q[k].push_back(d);
               cnt = 0;
            end
            if (cnt == 0) begin
               d.a_x_addr = ba;
               line = ba / TB_LINE;
            end
            cnt++;
         end
         d.a_x_len = 8'(cnt - 1); d.x_last = 1'b1;
         exp_q[k].push_back(d);
      end
   endtask

   // Compare process: every descriptor handshake is checked against the model queue.
   initial begin
      prev_stall[0] = 1'b0; prev_stall[1] = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int k = 0; k < 2; k++) begin
               exp_q[k].delete();
               prev_stall[k] = 1'b0;
            end
         end else begin
            for (int k = 0; k < 2; k++) begin
               if (ax_valid && rdy[k]) model_push(k, ax, (k == 0));
               if (prev_stall[k]) begin
                  chk("stall_valid_held", 64'(dv[k]), 64'd1);
                  chk("stall_desc_held", 64'(dsc[k]), 64'(prev_d[k]));
               end
               if (dv[k] && desc_ready) begin
                  if (exp_q[k].size() == 0) chk("unexpected_desc", 64'(dsc[k]), 64'd0);
                  else chk("model_desc", 64'(dsc[k]), 64'(exp_q[k].pop_front()));
               end
               prev_stall[k] = dv[k] && !desc_ready;
               prev_d[k] = dsc[k];
            end
         end
      end
   end

   task automatic send_ax(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int t = 0;
      @(posedge clk); #1;
      ax.id = next_id; ax.addr = addr; ax.len = len; ax.size = size; ax.burst = burst;
      ax.lock = 1'b0; ax.cache = 4'h3; ax.prot = 3'h2;
      next_id = next_id + 4'h1;
      ax_valid = 1'b1;
      @(negedge clk);
      while (!(rdy[0] && rdy[1]) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("ax_accept_timeout", 64'(t >= 100), 64'd0);
      @(posedge clk); #1;
      ax_valid = 1'b0;
   endtask

   task automatic chk_desc(input string nm, input logic [31:0] addr, input logic [7:0] len, input logic last);
      chk({nm, "_valid"}, 64'(dv[0]), 64'd1);
      chk({nm, "_addr"}, 64'(dsc[0].a_x_addr), 64'(addr));
      chk({nm, "_len"}, 64'(dsc[0].a_x_len), 64'(len));
      chk({nm, "_last"}, 64'(dsc[0].x_last), 64'(last));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 64'(dv[0]), 64'd0);
      chk("rst_desc", 64'(dsc[0]), 64'd0);
      chk("rst_ready", 64'(rdy[0]), 64'd1);
`ifdef AXI_LLC_SPLIT_STATS_EN
      chk("rst_split_cnt", 64'(cnt_aw), 64'd0);
`endif

      // single line
      send_ax(32'h100, 8'd7, 3'd3, BURST_INCR);
      @(negedge clk);
      chk_desc("incr_one", 32'h100, 8'd7, 1'b1);
      chk("rw_aw", 64'(dsc[0].rw), 64'd1);
      chk("rw_ar", 64'(dsc[1].rw), 64'd0);

      // crosses one line boundary
      send_ax(32'h130, 8'd7, 3'd3, BURST_INCR);
      @(negedge clk);
      chk_desc("split_a", 32'h130, 8'd1, 1'b0);
      @(negedge clk);
      chk_desc("split_b", 32'h140, 8'd5, 1'b1);
`ifdef AXI_LLC_SPLIT_STATS_EN
      chk("split_cnt_1", 64'(cnt_aw), 64'd1);
`endif

      // 256 beats over 32 lines
      send_ax(32'h0, 8'd255, 3'd3, BURST_INCR);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chk_desc("long", 32'(i * 64), 8'd7, (i == 31));
         chk("long_ready", 64'(rdy[0]), 64'(i == 31));
      end

      send_ax(32'h13C, 8'd15, 3'd2, BURST_FIXED);
      @(negedge clk);
      chk_desc("fixed", 32'h13C, 8'd15, 1'b1);
      send_ax(32'h118, 8'd3, 3'd3, BURST_WRAP);
      @(negedge clk);
      chk_desc("wrap", 32'h118, 8'd3, 1'b1);

      // backpressure on the split burst
      @(posedge clk); #1 desc_ready = 1'b0;
      send_ax(32'h130, 8'd7, 3'd3, BURST_INCR);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_desc("bp_hold", 32'h130, 8'd1, 1'b0);
         chk("bp_ready", 64'(rdy[0]), 64'd0);
      end
      @(posedge clk); #1 desc_ready = 1'b1;
      @(negedge clk);
      chk_desc("bp_release", 32'h130, 8'd1, 1'b0);
      @(negedge clk);
      chk_desc("bp_second", 32'h140, 8'd5, 1'b1);

      // reset in the middle of the long burst
      send_ax(32'h0, 8'd255, 3'd3, BURST_INCR);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 64'(dv[0]), 64'd0);
      chk("midrst_ready", 64'(rdy[0]), 64'd1);
`ifdef AXI_LLC_SPLIT_STATS_EN
      chk("midrst_split_cnt", 64'(cnt_aw), 64'd0);
`endif
      send_ax(32'h200, 8'd0, 3'd3, BURST_INCR);
      @(negedge clk);
      chk_desc("after_rst", 32'h200, 8'd0, 1'b1);

      // wraps past the top of the address space
      send_ax(32'hFFFF_FFF0, 8'd3, 3'd3, BURST_INCR);
      @(negedge clk);
      chk_desc("addr_wrap_a", 32'hFFFF_FFF0, 8'd1, 1'b0);
      @(negedge clk);
      chk_desc("addr_wrap_b", 32'h0, 8'd1, 1'b1);

      repeat (5) @(negedge clk);
      chk("q_empty_aw", 64'(exp_q[0].size()), 64'd0);
      chk("q_empty_ar", 64'(exp_q[1].size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
